// File: rtl/store_buffer_pkg.sv
// Shared CPU memory-side definitions: store size encodings and pending-store entry layout.
// Data memory decodes the same SSEL constants, so both sides stay in lockstep.
package store_buffer_pkg;

    localparam int XLEN   = 32;
    localparam int SSEL_W = 2;

    localparam logic [SSEL_W-1:0] SSEL_WORD = 2'b00;
    localparam logic [SSEL_W-1:0] SSEL_BYTE = 2'b01;
    localparam logic [SSEL_W-1:0] SSEL_HALF = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   pc;
        logic [SSEL_W-1:0] ssel;
    } sb_entry_t;

    // Reserved encoding 2'b11 falls through as a word store.
    function automatic logic is_subword(input logic [SSEL_W-1:0] ssel);
        return (ssel == SSEL_BYTE) || (ssel == SSEL_HALF);
    endfunction

endpackage

// File: rtl/sb_match.sv
// Load lookup: word-address compare against every live entry, youngest match wins.
// Latency: combinational. Backpressure: none, pure lookup.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [XLEN-3:0]            ent_wa   [DEPTH],
    input  logic [SSEL_W-1:0]          ent_ssel [DEPTH],
    input  logic [XLEN-1:0]            ent_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [XLEN-3:0]            ld_wa,
    output logic                       hit,
    output logic [SSEL_W-1:0]          ssel,
    output logic [XLEN-1:0]            data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        ssel = SSEL_WORD;
        data = '0;
        idx  = '0;
        // Walk from oldest to youngest so the last live match overrides earlier ones.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (ent_wa[idx] == ld_wa)) begin
                hit  = 1'b1;
                ssel = ent_ssel[idx];
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Pending-store FIFO between MEM and data memory with word-granular load forwarding.
// Latency: enqueue visible next cycle; drain/forward outputs combinational from state. Backpressure: st_ready low when full.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 st_valid,
    input  logic [XLEN-1:0]      st_addr,
    input  logic [XLEN-1:0]      st_data,
    input  logic [XLEN-1:0]      st_pc,
    input  logic [SSEL_W-1:0]    st_ssel,
    output logic                 st_ready,
    input  logic                 ld_valid,
    input  logic [XLEN-1:0]      ld_addr,
    output logic                 ld_fwd,
    output logic [XLEN-1:0]      ld_fwd_data,
    output logic                 ld_stall,
    input  logic                 drain_ok,
    output logic                 dm_we,
    output logic [XLEN-1:0]      dm_a,
    output logic [XLEN-1:0]      dm_wd,
    output logic [XLEN-1:0]      dm_pc,
    output logic [SSEL_W-1:0]    dm_ssel,
    output logic                 empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t       ent [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            enq;
    logic            deq;

    logic [XLEN-3:0]   ent_wa   [DEPTH];
    logic [SSEL_W-1:0] ent_ssel [DEPTH];
    logic [XLEN-1:0]   ent_data [DEPTH];
    logic              m_hit;
    logic [SSEL_W-1:0] m_ssel;
    logic [XLEN-1:0]   m_data;

    // Byte offset within the word plays no part in forwarding decisions.
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    // Gating with reset keeps the handshake quiet while reset is held low.
    assign empty    = (count == '0);
    assign st_ready = reset && (count < CW'(DEPTH));
    assign dm_we    = reset && drain_ok && !empty;
    assign enq      = st_valid && st_ready;
    assign deq      = dm_we;

    assign dm_a    = ent[head].addr;
    assign dm_wd   = ent[head].data;
    assign dm_pc   = ent[head].pc;
    assign dm_ssel = ent[head].ssel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (enq) begin
                ent[tail] <= '{addr: st_addr, data: st_data, pc: st_pc, ssel: st_ssel};
                tail      <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_wa[i]   = ent[i].addr[XLEN-1:2];
            ent_ssel[i] = ent[i].ssel;
            ent_data[i] = ent[i].data;
        end
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .ent_wa   (ent_wa),
        .ent_ssel (ent_ssel),
        .ent_data (ent_data),
        .head     (head),
        .count    (count),
        .ld_wa    (ld_addr[XLEN-1:2]),
        .hit      (m_hit),
        .ssel     (m_ssel),
        .data     (m_data)
    );

    // Sub-word stores can't be merged into a word load, so the load waits for the drain.
    assign ld_fwd      = ld_valid && m_hit && !is_subword(m_ssel);
    assign ld_stall    = ld_valid && m_hit &&  is_subword(m_ssel);
    assign ld_fwd_data = ld_fwd ? m_data : '0;

endmodule
